molecule_tally: RTL and testbench
=================================

# molecule_tally

Per-frame population counter for the osmosis display. It sits downstream of the molecule sprite blocks and consumes their `pos_x` outputs. Once per frame it snapshots every molecule's x position and scans the snapshot sequentially, one molecule per cycle. It then publishes left/right-of-membrane counts, their signed difference, and a debounced equilibrium flag for the HUD and the membrane control logic.

## Interface
Parameters:
- `N_MOL`, 8: number of molecules tallied; legal range 1..15.
- `MEMBRANE_X`, 10'd320: membrane column in pixels.
- `MOL_SIZE`, 10'd16: sprite edge length in pixels.
- `EQ_TOL`, 1: maximum |left − right| still counted as balanced.
- `EQ_FRAMES`, 60: consecutive balanced scans required before equilibrium is asserted.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-low. `reset == 0` clears all state immediately.
- `frame`, in, 1: one-cycle pulse per video frame.
- `freeze`, in, 1: when high, new scans are not started and all outputs hold.
- `pos_x_flat`, in, 10*N_MOL: molecule i's x position in bits [10i+9:10i].
- `left_cnt`, out, 4: molecules whose centre is left of the membrane.
- `right_cnt`, out, 4: molecules whose centre is at or right of the membrane.
- `diff`, out, 5 signed: `left_cnt − right_cnt`.
- `tally_valid`, out, 1: one-cycle pulse when the outputs above update.
- `equilibrium`, out, 1: balanced for at least `EQ_FRAMES` consecutive scans.
- `overrun`, out, 1: sticky; a `frame` pulse arrived while a scan was in progress.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE:
  - On `frame` with `freeze == 0`: capture all of `pos_x_flat` into the snapshot register, clear the accumulators, set idx = 0, go to SCAN.
  - On `frame` with `freeze == 1`: no action.
- SCAN: each cycle classify `snapshot[idx]`.
  - Centre = `pos_x + MOL_SIZE/2`, computed in 11 bits so it cannot wrap.
  - Centre < `MEMBRANE_X` → increment the left accumulator; otherwise increment the right accumulator.
  - If idx == N_MOL−1, go to DONE; otherwise increment idx.
- DONE:
  - Copy the accumulators to `left_cnt`/`right_cnt`.
  - Set `diff` = left − right, sign-extended to 5 bits.
  - Pulse `tally_valid`.
  - Update the equilibrium logic, then go to IDLE.
- Equilibrium:
  - Balanced scan (|diff_new| ≤ `EQ_TOL`): increment the balanced-frame counter, saturating at `EQ_FRAMES`. `equilibrium` is 1 when the counter equals `EQ_FRAMES`.
  - Unbalanced scan: clear the counter and `equilibrium` in the same DONE cycle.
- `frame` in SCAN or DONE: ignored for tallying, sets `overrun`. The running scan completes unchanged. Only reset clears `overrun`.
- `freeze` rising during SCAN: the scan completes normally. Freeze blocks only the next start.
- Mid-scan input changes: `pos_x_flat` changes after capture have no effect on the current scan.
- Counting invariant: `left_cnt + right_cnt == N_MOL` after every scan.
- Membrane edge: a molecule exactly on the membrane (centre == `MEMBRANE_X`) counts right.

## Timing
- Reset values:
  - State IDLE, idx 0.
  - `left_cnt`, `right_cnt`, `diff`: all 0.
  - `tally_valid`, `equilibrium`, `overrun`: all 0.
  - Balanced-frame counter 0.
- Latency:
  - `frame` sampled high at edge E0 (IDLE) → state SCAN after E0.
  - Edges E1..E_N classify idx 0..N−1.
  - Edge E_{N+1} (DONE) registers the outputs; `tally_valid` is high for the cycle after E_{N+1}.
  - Total: N_MOL+1 cycles from `frame` edge to updated outputs. For N_MOL = 8: 9 cycles.
- Next scan: a `frame` at the same edge as the DONE→IDLE transition counts as overrun. The next accepted start is the first IDLE cycle.
- Async reset: reset asserted mid-scan returns everything to reset values immediately with no partial publish. The first scan after reset release needs a fresh `frame`.
- Output registers: all outputs are registered and change only at DONE edges (`overrun` changes at its setting edge).

## Structure
- Shared package `osmosis_pkg`:
  - State enum (IDLE/SCAN/DONE).
  - `MOL_SIZE`.
  - 10-bit screen-coordinate width.
  - Default `MEMBRANE_X`.
- Sub-module `molecule_side_classify`: combinational. Takes a 10-bit `pos_x` and produces `is_left` using the 11-bit centre compare. Instantiated once on the idx-muxed snapshot entry.

## Test plan
- Reset then `frame` with N_MOL = 8, all pos_x = 100 → after 9 cycles: `left_cnt` = 8, `right_cnt` = 0, `diff` = +8, one `tally_valid` pulse, `equilibrium` = 0.
- Edge positions: pos_x = 312 (centre 320) vs pos_x = 311 (centre 319) → the first counts right, the second left. pos_x = 1023 → counts right with no wrap.
- Four molecules at x = 50 and four at x = 500 for 60 frames → `equilibrium` rises on the 60th `tally_valid`. A 61st frame at 7/1 split → `equilibrium` = 0 in that DONE cycle.
- `frame` pulsed at cycle 3 of a scan → scan completes with the original snapshot, `overrun` = 1 and stays 1 until reset. Change `pos_x_flat` mid-scan → counts unaffected.
- `freeze` = 1 across two `frame` pulses → no `tally_valid`, outputs unchanged. Release, then `frame` → normal scan.
- Reset asserted at scan cycle 5 → all outputs 0 immediately, no `tally_valid`. Release, then `frame` → correct full tally.

Source files
------------

// File: rtl/osmosis_pkg.sv
// Shared definitions for the osmosis display blocks: screen coordinate width,
// default sprite/membrane geometry and the tally scanner state encoding.
package osmosis_pkg;

    localparam int COORD_W = 10;

    localparam logic [COORD_W-1:0] DEF_MOL_SIZE   = 10'd16;
    localparam logic [COORD_W-1:0] DEF_MEMBRANE_X = 10'd320;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } tally_state_e;

endpackage

// File: rtl/molecule_side_classify.sv
// Decides which side of the membrane one molecule's centre lies on.
// A centre exactly on the membrane column counts as right.
module molecule_side_classify
    import osmosis_pkg::*;
#(
    parameter logic [COORD_W-1:0] MEMBRANE_X = DEF_MEMBRANE_X,
    parameter logic [COORD_W-1:0] MOL_SIZE   = DEF_MOL_SIZE
) (
    input  logic [COORD_W-1:0] pos_x,
    output logic               is_left
);

    // One extra bit so pos_x near the right screen edge cannot wrap to the left.
    logic [COORD_W:0] centre;

    assign centre  = {1'b0, pos_x} + {2'b00, MOL_SIZE[COORD_W-1:1]};
    assign is_left = (centre < {1'b0, MEMBRANE_X});

endmodule

// File: rtl/molecule_tally.sv
// Per-frame left/right molecule population counter with a debounced
// equilibrium flag; snapshots all positions and scans one molecule per cycle.
module molecule_tally
    import osmosis_pkg::*;
#(
    parameter int                 N_MOL      = 8,
    parameter logic [COORD_W-1:0] MEMBRANE_X = DEF_MEMBRANE_X,
    parameter logic [COORD_W-1:0] MOL_SIZE   = DEF_MOL_SIZE,
    parameter int                 EQ_TOL     = 1,
    parameter int                 EQ_FRAMES  = 60
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       frame,
    input  logic                       freeze,
    input  logic [COORD_W*N_MOL-1:0]   pos_x_flat,
    output logic [3:0]                 left_cnt,
    output logic [3:0]                 right_cnt,
    output logic signed [4:0]          diff,
    output logic                       tally_valid,
    output logic                       equilibrium,
    output logic                       overrun
);

    localparam int               BAL_W    = $clog2(EQ_FRAMES + 1);
    localparam logic [BAL_W-1:0] BAL_MAX  = BAL_W'(EQ_FRAMES);
    localparam logic [4:0]       TOL      = 5'(EQ_TOL);
    localparam logic [3:0]       LAST_IDX = 4'(N_MOL - 1);

    tally_state_e       state_q, state_d;
    logic [3:0]         idx_q, idx_d;
    logic [COORD_W-1:0] snap_q [N_MOL];
    logic [COORD_W-1:0] snap_d [N_MOL];
    logic [3:0]         lacc_q, lacc_d;
    logic [3:0]         racc_q, racc_d;
    logic [3:0]         left_q, left_d;
    logic [3:0]         right_q, right_d;
    logic signed [4:0]  diff_q, diff_d;
    logic               valid_q, valid_d;
    logic               eq_q, eq_d;
    logic [BAL_W-1:0]   bal_q, bal_d;
    logic               ovr_q, ovr_d;

    logic [COORD_W-1:0] cur_x;
    logic               cur_left;
    logic signed [4:0]  diff_new;
    logic [4:0]         diff_u;
    logic [4:0]         diff_abs;

    always_comb begin
        cur_x = '0;
        for (int i = 0; i < N_MOL; i++) begin
            if (idx_q == 4'(i)) cur_x = snap_q[i];
        end
    end

    molecule_side_classify #(
        .MEMBRANE_X (MEMBRANE_X),
        .MOL_SIZE   (MOL_SIZE)
    ) u_classify (
        .pos_x   (cur_x),
        .is_left (cur_left)
    );

    assign diff_new = $signed({1'b0, lacc_q}) - $signed({1'b0, racc_q});
    assign diff_u   = diff_new;
    assign diff_abs = diff_u[4] ? (~diff_u + 5'd1) : diff_u;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        lacc_d  = lacc_q;
        racc_d  = racc_q;
        left_d  = left_q;
        right_d = right_q;
        diff_d  = diff_q;
        valid_d = 1'b0;
        eq_d    = eq_q;
        bal_d   = bal_q;
        ovr_d   = ovr_q;

        unique case (state_q)
            IDLE: begin
                if (frame && !freeze) begin
                    for (int i = 0; i < N_MOL; i++) begin
                        snap_d[i] = pos_x_flat[COORD_W*i +: COORD_W];
                    end
                    lacc_d  = '0;
                    racc_d  = '0;
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (cur_left) lacc_d = lacc_q + 4'd1;
                else          racc_d = racc_q + 4'd1;
                if (idx_q == LAST_IDX) state_d = DONE;
                else                   idx_d   = idx_q + 4'd1;
                if (frame) ovr_d = 1'b1;
            end
            DONE: begin
                left_d  = lacc_q;
                right_d = racc_q;
                diff_d  = diff_new;
                valid_d = 1'b1;
                if (diff_abs <= TOL) begin
                    if (bal_q != BAL_MAX) bal_d = bal_q + 1'b1;
                    eq_d = (bal_d == BAL_MAX);
                end else begin
                    bal_d = '0;
                    eq_d  = 1'b0;
                end
                if (frame) ovr_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            snap_q  <= '{default: '0};
            lacc_q  <= '0;
            racc_q  <= '0;
            left_q  <= '0;
            right_q <= '0;
            diff_q  <= '0;
            valid_q <= 1'b0;
            eq_q    <= 1'b0;
            bal_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            lacc_q  <= lacc_d;
            racc_q  <= racc_d;
            left_q  <= left_d;
            right_q <= right_d;
            diff_q  <= diff_d;
            valid_q <= valid_d;
            eq_q    <= eq_d;
            bal_q   <= bal_d;
            ovr_q   <= ovr_d;
        end
    end

    assign left_cnt    = left_q;
    assign right_cnt   = right_q;
    assign diff        = diff_q;
    assign tally_valid = valid_q;
    assign equilibrium = eq_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_molecule_tally.sv
// Scoreboard bench for molecule_tally: directed position patterns with
// hand-computed tallies, popped and compared on every tally_valid pulse.
module tb_molecule_tally;

    localparam int N = 8;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 frame = 1'b0;
    logic                 freeze = 1'b0;
    logic [10*N-1:0]      pos_x_flat = '0;
    logic [3:0]           left_cnt, right_cnt;
    logic signed [4:0]    diff;
    logic                 tally_valid, equilibrium, overrun;

    molecule_tally #(
        .N_MOL      (N),
        .MEMBRANE_X (10'd320),
        .MOL_SIZE   (10'd16),
        .EQ_TOL     (1),
        .EQ_FRAMES  (60)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame       (frame),
        .freeze      (freeze),
        .pos_x_flat  (pos_x_flat),
        .left_cnt    (left_cnt),
        .right_cnt   (right_cnt),
        .diff        (diff),
        .tally_valid (tally_valid),
        .equilibrium (equilibrium),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int l;
        int r;
        int d;
        int eq;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   pops     = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Monitor: every tally_valid pulse must match the oldest expectation.
    exp_t e;
    always @(negedge clk) begin
        if (reset && tally_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_tally_valid: got a pulse, expected none");
            end else begin
                e = sb.pop_front();
                chk("left_cnt",    int'(left_cnt),    e.l);
                chk("right_cnt",   int'(right_cnt),   e.r);
                chk("diff",        int'(diff),        e.d);
                chk("equilibrium", int'(equilibrium), e.eq);
            end
            pops++;
        end
    end

    task automatic set_all(input int v);
        for (int i = 0; i < N; i++) pos_x_flat[10*i +: 10] = 10'(v);
    endtask

    task automatic set_pos(input int i, input int v);
        pos_x_flat[10*i +: 10] = 10'(v);
    endtask

    task automatic frame_pulse();
        @(posedge clk); #1 frame = 1'b1;
        @(posedge clk); #1 frame = 1'b0;
    endtask

    task automatic wait_tally(input int start);
        for (int c = 0; c < 40 && pops == start; c++) @(posedge clk);
        chk("tally_pulses", pops - start, 1);
    endtask

    task automatic run(input int l, input int r, input int eq);
        int s;
        s = pops;
        sb.push_back('{l, r, l - r, eq});
        frame_pulse();
        wait_tally(s);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_left"},    int'(left_cnt),    0);
        chk({tag, "_right"},   int'(right_cnt),   0);
        chk({tag, "_diff"},    int'(diff),        0);
        chk({tag, "_valid"},   int'(tally_valid), 0);
        chk({tag, "_eq"},      int'(equilibrium), 0);
        chk({tag, "_overrun"}, int'(overrun),     0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int s;
        #2 reset = 1'b0;
        #10;
        chk_all_zero("reset");
        @(posedge clk); #1 reset = 1'b1;

        // All left, with exact latency: valid appears 9 edges after the frame edge.
        set_all(100);
        s = pops;
        sb.push_back('{8, 0, 8, 0});
        frame_pulse();
        repeat (8) @(posedge clk);
        #1 chk("latency_not_early", int'(tally_valid), 0);
        @(posedge clk);
        #1 chk("latency_valid", int'(tally_valid), 1);
        @(posedge clk);
        #1 chk("valid_one_cycle", int'(tally_valid), 0);
        chk("first_scan_popped", pops - s, 1);

        // Membrane edge: centre 320 is right, 319 is left.
        set_all(312);
        run(0, 8, 0);
        set_all(311);
        run(8, 0, 0);
        set_pos(0, 312); set_pos(1, 311); set_pos(2, 1023); set_pos(3, 0);
        set_pos(4, 304); set_pos(5, 305); set_pos(6, 700);  set_pos(7, 0);
        run(5, 3, 0);

        // Balanced 4/4 for 60 scans, then a 7/1 split drops equilibrium.
        for (int i = 0; i < N; i++) set_pos(i, (i < 4) ? 50 : 500);
        for (int k = 1; k <= 60; k++) run(4, 4, (k == 60) ? 1 : 0);
        for (int i = 0; i < N; i++) set_pos(i, (i < 7) ? 50 : 500);
        run(7, 1, 0);

        // Overrun: frame during the scan, positions changed after capture.
        chk("overrun_before", int'(overrun), 0);
        for (int i = 0; i < N; i++) set_pos(i, (i < 3) ? 50 : 500);
        s = pops;
        sb.push_back('{3, 5, -2, 0});
        frame_pulse();
        @(posedge clk);
        @(posedge clk); #1 frame = 1'b1; set_all(100);
        @(posedge clk); #1 frame = 1'b0;
        chk("overrun_set", int'(overrun), 1);
        wait_tally(s);
        repeat (20) @(posedge clk);
        chk("no_extra_scan", pops - s, 1);

        // Freeze blocks new starts; outputs hold.
        #1 freeze = 1'b1;
        s = pops;
        frame_pulse();
        repeat (3) @(posedge clk);
        frame_pulse();
        repeat (20) @(posedge clk);
        #1 chk("freeze_no_valid", pops - s, 0);
        chk("freeze_left",  int'(left_cnt),  3);
        chk("freeze_right", int'(right_cnt), 5);
        chk("freeze_diff",  int'(diff),      -2);
        chk("overrun_sticky", int'(overrun), 1);
        freeze = 1'b0;
        set_all(500);
        run(0, 8, 0);
        chk("overrun_still_set", int'(overrun), 1);

        // Async reset in the middle of a scan: no publish.
        set_all(100);
        s = pops;
        frame_pulse();
        repeat (4) @(posedge clk);
        #3 reset = 1'b0;
        #1 chk_all_zero("midscan_reset");
        @(posedge clk); #1 reset = 1'b1;
        repeat (15) @(posedge clk);
        chk("no_valid_after_reset", pops - s, 0);
        set_all(311);
        run(8, 0, 0);

        repeat (5) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
